// File: rtl/wb_writer.sv
// rtl/wb_writer.sv - writeback sequencer merging ALU and load results onto the regfile write port
// Buffers ALU results, arbitrates against loads with a starvation bound, and tracks pending rd.
module wb_writer #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          iss_valid,
    input  logic [4:0]                    iss_rd,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [4:0]                    alu_rd,
    input  logic [XLEN-1:0]               alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [4:0]                    mem_rd,
    input  logic [XLEN-1:0]               mem_data,
    output logic                          rf_we,
    output logic [4:0]                    rf_rd,
    output logic [XLEN-1:0]               rf_wdata,
    input  logic [4:0]                    q_rs1,
    input  logic [4:0]                    q_rs2,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]      fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve_cnt;
    logic [31:0]     busy;
    logic [31:0]     busy_next;

    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            force_alu;
    logic            mem_sel;
    logic            sel;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign alu_ready = !rst && !full;
    assign push      = alu_valid && alu_ready;

    // Once loads have won STARVE_MAX times in a row over a waiting ALU result, the ALU gets the slot.
    assign force_alu = !empty && (starve_cnt == SW'(STARVE_MAX));
    assign mem_ready = !rst && !force_alu;
    assign mem_sel   = mem_valid && mem_ready;
    assign pop       = !rst && !mem_sel && !empty;
    assign sel       = mem_sel || pop;
    assign sel_rd    = mem_sel ? mem_rd : fifo_rd[rd_ptr];
    assign sel_data  = mem_sel ? mem_data : fifo_data[rd_ptr];

    assign fifo_count = count;
    assign rs1_busy   = (q_rs1 != 5'd0) && busy[q_rs1];
    assign rs2_busy   = (q_rs2 != 5'd0) && busy[q_rs2];
    assign idle       = empty && !rf_we && (busy == 32'd0);

    // Issue set is applied after the writeback clear so a same-cycle reissue keeps the bit.
    always_comb begin
        busy_next = busy;
        if (rf_we) begin
            busy_next[rf_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            busy_next[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= alu_rd;
            fifo_data[wr_ptr] <= alu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            busy       <= '0;
            rf_we      <= 1'b0;
            rf_rd      <= 5'd0;
            rf_wdata   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            if (pop || empty) begin
                starve_cnt <= '0;
            end else if (mem_sel && (starve_cnt != SW'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            busy <= busy_next;

            // Results for x0 are consumed without disturbing the last written address/data.
            if (sel && (sel_rd != 5'd0)) begin
                rf_we    <= 1'b1;
                rf_rd    <= sel_rd;
                rf_wdata <= sel_data;
            end else begin
                rf_we    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_writer.sv
// tb/tb_wb_writer.sv - self-checking bench for wb_writer with a queue-based reference model
module tb_wb_writer;

    localparam int DEPTH = 4;
    localparam int SMAX  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [4:0]  q_rs1 = '0;
    logic [4:0]  q_rs2 = '0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [2:0]  fifo_count;
    logic        idle;

    wb_writer #(.XLEN(32), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .fifo_count(fifo_count), .idle(idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [4:0]  m_q_rd[$];
    logic [31:0] m_q_data[$];
    int          m_starve;
    bit [31:0]   m_busy;
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;

    // DUT values captured at the latest step sample point
    logic        s_alu_ready, s_mem_ready, s_rs1_busy, s_rf_we;
    logic [4:0]  s_rf_rd;
    logic [2:0]  s_count;

    typedef struct packed {
        logic        iv;
        logic [4:0]  ir;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic [4:0]  r1;
        logic        e_rs1;
        logic        e_mready;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q_rd.delete();
        m_q_data.delete();
        m_starve = 0;
        m_busy   = '0;
        m_we     = 1'b0;
        m_rd     = '0;
        m_wd     = '0;
    endtask

    // Drive one cycle of inputs, compare every output against the model, then advance the model.
    task automatic step(input bit iv, input logic [4:0] ir, input bit av, input logic [4:0] ar,
                        input logic [31:0] ad, input bit mv, input logic [4:0] mr,
                        input logic [31:0] md, input logic [4:0] r1, input logic [4:0] r2);
        int n;
        bit aready, push, force_alu, mready, msel, pop;
        logic [4:0]  srd;
        logic [31:0] sd;
        @(negedge clk);
        iss_valid = iv; iss_rd = ir;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        mem_valid = mv; mem_rd = mr; mem_data = md;
        q_rs1 = r1; q_rs2 = r2;
        #1;
        n         = m_q_rd.size();
        aready    = (n < DEPTH);
        push      = av && aready;
        force_alu = (n > 0) && (m_starve == SMAX);
        mready    = !force_alu;
        msel      = mv && mready;
        pop       = !msel && (n > 0);
        s_alu_ready = alu_ready; s_mem_ready = mem_ready; s_rs1_busy = rs1_busy;
        s_rf_we = rf_we; s_rf_rd = rf_rd; s_count = fifo_count;
        chk("alu_ready", alu_ready, aready);
        chk("mem_ready", mem_ready, mready);
        chk("rs1_busy", rs1_busy, (r1 != 0) && m_busy[r1]);
        chk("rs2_busy", rs2_busy, (r2 != 0) && m_busy[r2]);
        chk("fifo_count", fifo_count, n);
        chk("rf_we", rf_we, m_we);
        if (m_we) begin
            chk("rf_rd", rf_rd, m_rd);
            chk("rf_wdata", rf_wdata, m_wd);
        end
        chk("idle", idle, (n == 0) && !m_we && (m_busy == 0));

        srd = '0; sd = '0;
        if (msel) begin
            srd = mr; sd = md;
        end else if (pop) begin
            srd = m_q_rd[0]; sd = m_q_data[0];
        end
        if (m_we) m_busy[m_rd] = 1'b0;
        if (iv && ir != 0) m_busy[ir] = 1'b1;
        if ((msel || pop) && srd != 0) begin
            m_we = 1'b1; m_rd = srd; m_wd = sd;
        end else begin
            m_we = 1'b0;
        end
        if (pop || n == 0) m_starve = 0;
        else if (msel && m_starve < SMAX) m_starve++;
        if (pop) begin
            void'(m_q_rd.pop_front());
            void'(m_q_data.pop_front());
        end
        if (push) begin
            m_q_rd.push_back(ar);
            m_q_data.push_back(ad);
        end
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (m_q_rd.size() == 0 && !m_we) break;
            idle_step();
        end
        chk("drain_empty", m_q_rd.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        iss_valid = 0; alu_valid = 0; mem_valid = 0; q_rs1 = 5'd5;
        rst = 1'b1;
        #1;
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_rs1_busy", rs1_busy, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_idle", idle, 1);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
    endtask

    task automatic random_cycles(input int cycles);
        bit iv, av, mv;
        logic [4:0] ir, ar, mr;
        for (int i = 0; i < cycles; i++) begin
            ir = 5'($urandom_range(0, 31));
            iv = ($urandom_range(0, 2) == 0);
            if (m_busy[ir]) iv = 1'b0;
            av = ($urandom_range(0, 1) == 1);
            mv = ($urandom_range(0, 2) != 0);
            ar = 5'($urandom_range(0, 31));
            mr = 5'($urandom_range(0, 31));
            step(iv, ir, av, ar, $urandom, mv, mr, $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'd5, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
        tbl[1]  = '{1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        tbl[2]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
        tbl[3]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF};
        tbl[4]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h1234, 5'd5, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF};
        tbl[5]  = '{1'b1, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd0, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF};
        tbl[6]  = '{1'b1, 5'd7, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd7, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF};
        tbl[7]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'hAA,   5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 32'hAA};
        tbl[8]  = '{1'b1, 5'd7, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 32'hAA};
        tbl[9]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'hBB,   5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 32'hBB};
        tbl[10] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 32'hBB};
        tbl[11] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd7, 1'b0, 1'b1, 1'b0, 5'd7, 32'hBB};
    end

    initial begin
        bit seen14, checked_full;
        int k;

        model_clear();
        repeat (2) @(posedge clk);
        do_reset();

        // Directed vectors: ALU writeback, x0 handling, busy set/clear and collision
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].iv, tbl[i].ir, tbl[i].av, tbl[i].ar, tbl[i].ad,
                 tbl[i].mv, tbl[i].mr, tbl[i].md, tbl[i].r1, 5'd0);
            chk($sformatf("tbl%0d_rs1_busy", i), s_rs1_busy, tbl[i].e_rs1);
            chk($sformatf("tbl%0d_mem_ready", i), s_mem_ready, tbl[i].e_mready);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_rf_we", i), rf_we, tbl[i].e_we);
            chk($sformatf("tbl%0d_rf_rd", i), rf_rd, tbl[i].e_rd);
            chk($sformatf("tbl%0d_rf_wdata", i), rf_wdata, tbl[i].e_wd);
        end
        drain();

        // Fill: loads to x0 stream while five ALU results arrive; the fifth must wait, then land
        k = 0; seen14 = 0; checked_full = 0;
        for (int c = 0; c < 24 && !seen14; c++) begin
            step(0, 0, k < 5, 5'(10 + k), 32'h100 + k, 1, 0, 32'h55, 0, 0);
            if (k == 4 && !checked_full) begin
                checked_full = 1;
                chk("fill_count_at_full", s_count, 4);
                chk("fill_alu_ready_at_full", s_alu_ready, 0);
            end
            if (s_rf_we && s_rf_rd == 5'd14) seen14 = 1;
            if (k < 5 && s_alu_ready) k++;
        end
        chk("fill_fifth_written", seen14, 1);
        drain();

        // Starvation: one buffered ALU entry against continuous loads
        step(0, 0, 1, 5'd20, 32'h2020, 1, 5'd21, 32'h21, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 1, 5'(22 + i), 32'h22 + i, 0, 0);
            chk($sformatf("starve_mem_win%0d", i), s_mem_ready, 1);
        end
        step(0, 0, 0, 0, 0, 1, 5'd25, 32'h25, 0, 0);
        chk("starve_forced_mem_ready", s_mem_ready, 0);
        idle_step();
        chk("starve_alu_we", s_rf_we, 1);
        chk("starve_alu_rd", s_rf_rd, 20);
        drain();

        // Random traffic with a reset in the middle of it
        random_cycles(60);
        do_reset();
        random_cycles(1500);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
